game_sequencer: RTL and testbench



---
 rtl/game_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Frame-rate controller for the block-dodger game. It runs the start/play/over FSM and
// owns the player and block positions, collision detection, block respawn and the score.
module game_sequencer #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int PLAYER_W    = 110,
  parameter int PLAYER_H    = 20,
  parameter int BLOCK_W     = 110,
  parameter int BLOCK_H     = 32,
  parameter int PLAYER_Y    = 440,
  parameter int PLAYER_STEP = 4,
  parameter int BLOCK_SPEED = 2,
  parameter int OVER_FRAMES = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_start,
  output logic [1:0]  state,
  output logic        game_over,
  output logic [9:0]  player_x,
  output logic [9:0]  player_y,
  output logic [9:0]  block0_x,
  output logic [9:0]  block0_y,
  output logic [9:0]  block1_x,
  output logic [9:0]  block1_y,
  output logic [9:0]  block2_x,
  output logic [9:0]  block2_y,
  output logic [15:0] score
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam int             FCW        = $clog2(OVER_FRAMES + 1);
  localparam logic [FCW-1:0] FRAMES_MAX = FCW'(OVER_FRAMES);

  localparam logic [9:0]  PX_MAX = 10'(SCREEN_W - PLAYER_W);
  localparam logic [9:0]  PX_RST = 10'((SCREEN_W - PLAYER_W) / 2);
  localparam logic [9:0]  STEP   = 10'(PLAYER_STEP);
  localparam logic [10:0] STEP11 = 11'(PLAYER_STEP);
  localparam logic [10:0] PW     = 11'(PLAYER_W);
  localparam logic [10:0] PH     = 11'(PLAYER_H);
  localparam logic [10:0] BW     = 11'(BLOCK_W);
  localparam logic [10:0] BH     = 11'(BLOCK_H);
  localparam logic [10:0] PY     = 11'(PLAYER_Y);
  localparam logic [10:0] SH     = 11'(SCREEN_H);
  localparam logic [10:0] SPEED  = 11'(BLOCK_SPEED);

  // Start-screen layout: blocks spread across the width and staggered by a third of the height.
  localparam logic [2:0][9:0] BX_RST = {10'(SCREEN_W - BLOCK_W), 10'((SCREEN_W - BLOCK_W) / 2), 10'd0};
  localparam logic [2:0][9:0] BY_RST = {10'(2 * SCREEN_H / 3), 10'(SCREEN_H / 3), 10'd0};

  logic [1:0]       state_q, state_d;
  logic             game_over_q, game_over_d;
  logic [9:0]       px_q, px_d;
  logic [2:0][9:0]  bx_q, bx_d;
  logic [2:0][9:0]  by_q, by_d;
  logic [15:0]      score_q, score_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             start_prev_q, start_prev_d;

  logic             start_rise;
  logic [2:0]       hit;
  logic [2:0]       wrap;
  logic [2:0][10:0] fall_y;
  logic [2:0][9:0]  spawn_x;

  assign start_rise = btn_start & ~start_prev_q;
  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign spawn_x    = {{1'b0, lfsr_q[15:7]}, {1'b0, lfsr_q[12:4]}, {1'b0, lfsr_q[8:0]}};

  // Overlap and fall are evaluated in 11 bits so edge sums near the screen limits cannot wrap.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hit[i] = ({1'b0, px_q} < {1'b0, bx_q[i]} + BW) &&
               ({1'b0, bx_q[i]} < {1'b0, px_q} + PW) &&
               (PY < {1'b0, by_q[i]} + BH) &&
               ({1'b0, by_q[i]} < PY + PH);
      fall_y[i] = {1'b0, by_q[i]} + SPEED;
      wrap[i]   = (fall_y[i] >= SH);
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    px_d         = px_q;
    bx_d         = bx_q;
    by_d         = by_q;
    score_d      = score_q;
    frame_cnt_d  = frame_cnt_q;
    start_prev_d = frame_tick ? btn_start : start_prev_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick && start_rise) begin
          state_d = ST_PLAY;
          px_d    = PX_RST;
          bx_d    = BX_RST;
          by_d    = BY_RST;
          score_d = '0;
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          if (|hit) begin
            state_d     = ST_OVER;
            frame_cnt_d = '0;
          end else begin
            if (btn_left && !btn_right) begin
              px_d = (px_q >= STEP) ? px_q - STEP : '0;
            end else if (btn_right && !btn_left) begin
              px_d = ({1'b0, px_q} + STEP11 >= {1'b0, PX_MAX}) ? PX_MAX : px_q + STEP;
            end
            for (int i = 0; i < 3; i++) begin
              if (wrap[i]) begin
                by_d[i] = '0;
                bx_d[i] = spawn_x[i];
                if (score_d != 16'hFFFF) score_d = score_d + 16'd1;
              end else begin
                by_d[i] = fall_y[i][9:0];
              end
            end
          end
        end
      end
      ST_OVER: begin
        if (frame_tick) begin
          if (frame_cnt_q == FRAMES_MAX && start_rise) begin
            state_d = ST_IDLE;
          end else if (frame_cnt_q != FRAMES_MAX) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    game_over_d = (state_d == ST_OVER);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      game_over_q  <= 1'b0;
      px_q         <= PX_RST;
      bx_q         <= BX_RST;
      by_q         <= BY_RST;
      score_q      <= '0;
      frame_cnt_q  <= '0;
      lfsr_q       <= 16'hACE1;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      game_over_q  <= game_over_d;
      px_q         <= px_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      score_q      <= score_d;
      frame_cnt_q  <= frame_cnt_d;
      lfsr_q       <= lfsr_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign state     = state_q;
  assign game_over = game_over_q;
  assign player_x  = px_q;
  assign player_y  = 10'(PLAYER_Y);
  assign block0_x  = bx_q[0];
  assign block0_y  = by_q[0];
  assign block1_x  = bx_q[1];
  assign block1_y  = by_q[1];
  assign block2_x  = bx_q[2];
  assign block2_y  = by_q[2];
  assign score     = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a behavioural game model queues the expected
// outputs for each frame tick and an independent monitor compares them after the edge.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_start = 1'b0;
  logic [1:0]  state;
  logic        game_over;
  logic [9:0]  player_x, player_y;
  logic [9:0]  block0_x, block0_y, block1_x, block1_y, block2_x, block2_y;
  logic [15:0] score;

  game_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_start  (btn_start),
    .state      (state),
    .game_over  (game_over),
    .player_x   (player_x),
    .player_y   (player_y),
    .block0_x   (block0_x),
    .block0_y   (block0_y),
    .block1_x   (block1_x),
    .block1_y   (block1_y),
    .block2_x   (block2_x),
    .block2_y   (block2_y),
    .score      (score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic [9:0]  px;
    logic [9:0]  b0x, b0y, b1x, b1y, b2x, b2y;
    logic [15:0] score;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] lfsr_tab [65535];
  int          clk_cnt = 0;
  logic        tick_seen = 1'b0;

  // Game model: plain integers following the game rules.
  int m_st, m_px, m_frames, m_score;
  int m_bx[3];
  int m_by[3];
  bit m_sp;

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic model_load_positions();
    m_px    = 265;
    m_bx[0] = 0;   m_by[0] = 0;
    m_bx[1] = 265; m_by[1] = 160;
    m_bx[2] = 530; m_by[2] = 320;
  endtask

  task automatic model_reset();
    m_st = 0; m_score = 0; m_frames = 0; m_sp = 1'b0;
    model_load_positions();
  endtask

  function automatic int spawn_x(input int i, input int lf);
    int sh;
    sh = (i == 0) ? 0 : (i == 1) ? 4 : 7;
    return (lf >> sh) % 512;
  endfunction

  task automatic model_step(input bit l, input bit r, input bit s, input int lf);
    bit   rise;
    bit   any_hit;
    exp_t e;
    rise = s && !m_sp;
    m_sp = s;
    case (m_st)
      0: if (rise) begin
        m_st = 1; m_score = 0;
        model_load_positions();
      end
      1: begin
        any_hit = 1'b0;
        for (int i = 0; i < 3; i++)
          if (m_px < m_bx[i] + 110 && m_bx[i] < m_px + 110 && 440 < m_by[i] + 32 && m_by[i] < 460)
            any_hit = 1'b1;
        if (any_hit) begin
          m_st = 2; m_frames = 0;
        end else begin
          if (l && !r)      m_px = (m_px - 4 < 0) ? 0 : m_px - 4;
          else if (r && !l) m_px = (m_px + 4 > 530) ? 530 : m_px + 4;
          for (int i = 0; i < 3; i++) begin
            m_by[i] = m_by[i] + 2;
            if (m_by[i] >= 480) begin
              m_by[i] = 0;
              m_bx[i] = spawn_x(i, lf);
              if (m_score < 65535) m_score++;
            end
          end
        end
      end
      default: begin
        if (m_frames == 120 && rise) m_st = 0;
        else if (m_frames < 120)     m_frames++;
      end
    endcase
    e.st = 2'(m_st); e.px = 10'(m_px); e.score = 16'(m_score);
    e.b0x = 10'(m_bx[0]); e.b0y = 10'(m_by[0]);
    e.b1x = 10'(m_bx[1]); e.b1y = 10'(m_by[1]);
    e.b2x = 10'(m_bx[2]); e.b2y = 10'(m_by[2]);
    exp_q.push_back(e);
  endtask

  // Clocks since reset release = number of LFSR shifts the DUT has made.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_cnt <= 0;
    else        clk_cnt <= clk_cnt + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_seen <= 1'b0;
    else        tick_seen <= frame_tick;
  end

  always @(negedge clk) begin
    if (tick_seen) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard: DUT ticked with no expected entry (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_state",     int'(state),     int'(mon_e.st));
        check("sb_game_over", int'(game_over), int'(mon_e.st == 2'd2));
        check("sb_player_x",  int'(player_x),  int'(mon_e.px));
        check("sb_player_y",  int'(player_y),  440);
        check("sb_block0_x",  int'(block0_x),  int'(mon_e.b0x));
        check("sb_block0_y",  int'(block0_y),  int'(mon_e.b0y));
        check("sb_block1_x",  int'(block1_x),  int'(mon_e.b1x));
        check("sb_block1_y",  int'(block1_y),  int'(mon_e.b1y));
        check("sb_block2_x",  int'(block2_x),  int'(mon_e.b2x));
        check("sb_block2_y",  int'(block2_y),  int'(mon_e.b2y));
        check("sb_score",     int'(score),     int'(mon_e.score));
      end
    end
  end

  task automatic do_tick(input bit l, input bit r, input bit s);
    @(posedge clk);
    #1;
    btn_left = l; btn_right = r; btn_start = s;
    frame_tick = 1'b1;
    model_step(l, r, s, int'(lfsr_tab[clk_cnt % 65535]));
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"},     int'(state),     0);
    check({tag, "_game_over"}, int'(game_over), 0);
    check({tag, "_player_x"},  int'(player_x),  265);
    check({tag, "_player_y"},  int'(player_y),  440);
    check({tag, "_block0_x"},  int'(block0_x),  0);
    check({tag, "_block0_y"},  int'(block0_y),  0);
    check({tag, "_block1_x"},  int'(block1_x),  265);
    check({tag, "_block1_y"},  int'(block1_y),  160);
    check({tag, "_block2_x"},  int'(block2_x),  530);
    check({tag, "_block2_y"},  int'(block2_y),  320);
    check({tag, "_score"},     int'(score),     0);
  endtask

  initial begin
    logic [15:0] v;
    bit          dl, dr;
    v = 16'hACE1;
    for (int i = 0; i < 65535; i++) begin
      lfsr_tab[i] = v;
      v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    end
    model_reset();

    #23 rst_n = 1'b1;
    check_reset("por");

    repeat (3) do_tick(1'b0, 1'b0, 1'b0);
    check("idle_state", int'(state), 0);
    check("idle_player_x", int'(player_x), 265);
    check("idle_block2_y", int'(block2_y), 320);

    // Game 1: movement, saturation at the left wall, both-button hold, then run right into a block.
    do_tick(1'b0, 1'b0, 1'b1);
    check("start_state", int'(state), 1);
    do_tick(1'b0, 1'b1, 1'b0);
    check("first_move_px", int'(player_x), 269);
    check("first_fall_b0y", int'(block0_y), 2);
    repeat (70) do_tick(1'b1, 1'b0, 1'b0);
    check("left_sat_px", int'(player_x), 0);
    repeat (5) do_tick(1'b1, 1'b1, 1'b0);
    check("both_hold_px", int'(player_x), 0);
    for (int i = 0; i < 400 && m_st == 1; i++) do_tick(1'b0, 1'b1, 1'b0);
    check("reached_over", int'(state), 2);

    // Game-over hold: presses before the 120th frame are ignored.
    repeat (50) do_tick(1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b1);
    check("over_press_50", int'(state), 2);
    do_tick(1'b0, 1'b0, 1'b0);
    repeat (67) do_tick(1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b1);
    check("over_press_119", int'(state), 2);
    do_tick(1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b1);
    check("over_to_idle", int'(state), 0);
    check("over_to_idle_go", int'(game_over), 0);

    // Start held high across the return to IDLE must not restart the game.
    repeat (3) do_tick(1'b0, 1'b0, 1'b1);
    check("held_start_idle", int'(state), 0);
    do_tick(1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b1);
    check("restart_state", int'(state), 1);
    check("restart_score", int'(score), 0);
    check("restart_px", int'(player_x), 265);
    check("restart_b1y", int'(block1_y), 160);

    // Game 2: stand still; block1 falls onto the player.
    do_tick(1'b0, 1'b0, 1'b0);
    repeat (124) do_tick(1'b0, 1'b0, 1'b0);
    check("pre_hit_state", int'(state), 1);
    check("pre_hit_b1y", int'(block1_y), 410);
    do_tick(1'b0, 1'b0, 1'b0);
    check("hit_state", int'(state), 2);
    check("hit_game_over", int'(game_over), 1);
    check("hit_b1y_frozen", int'(block1_y), 410);
    check("hit_px", int'(player_x), 265);
    check("hit_score", int'(score), 1);

    // Game 3: back to play, then async reset mid-game.
    for (int i = 0; i < 300 && m_st == 2; i++) do_tick(1'b0, 1'b0, 1'(i % 2));
    do_tick(1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b1);
    repeat (20) do_tick(1'b0, 1'b0, 1'b0);
    check("pre_reset_state", int'(state), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("async");
    exp_q.delete();
    model_reset();
    btn_start = 1'b0;
    #10 rst_n = 1'b1;

    // Randomised play across several games.
    dl = 1'b0; dr = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        dl = 1'($urandom_range(0, 1));
        dr = 1'($urandom_range(0, 1));
      end
      do_tick(dl, dr, 1'($urandom_range(0, 3) == 0));
    end

    repeat (4) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
